// File: rtl/serial_lshr_unit_if.sv
// Handshake bundle for serial_lshr_unit: operand/request channel, result/response channel, busy flag.
interface serial_lshr_unit_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] I0;
  logic [WIDTH-1:0] I1;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] O;
  logic             out_valid;
  logic             out_ready;
  logic             busy;

  modport master (
    output I0, I1, in_valid, out_ready,
    input  in_ready, O, out_valid, busy
  );

  modport slave (
    input  I0, I1, in_valid, out_ready,
    output in_ready, O, out_valid, busy
  );
endinterface

// File: rtl/serial_lshr_unit.sv
// Iterative logical shift-right: O = I0 >> I1, one bit position per clock.
// The shift amount is clamped to WIDTH so worst-case latency is bounded.
module serial_lshr_unit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                CLK,
  input  logic                ASYNCRESETN,
  serial_lshr_unit_if.slave   bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] WIDTH_V   = WIDTH'(WIDTH);
  localparam logic [CNT_W-1:0] WIDTH_CNT = CNT_W'(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [CNT_W-1:0] n_sat;

  // State, data and remaining-shift registers with async active-low reset.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, datapath update and handshake outputs.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    // Compare at full operand width before narrowing to the counter width.
    n_sat   = (bus.I1 >= WIDTH_V) ? WIDTH_CNT : CNT_W'(bus.I1);

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          data_d  = bus.I0;
          cnt_d   = n_sat;
          state_d = (n_sat != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        // A plain shift (not a concatenation) keeps WIDTH=1 legal.
        data_d = data_q >> 1;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
    bus.busy      = (state_q != IDLE);
    bus.O         = (state_q == DONE) ? data_q : '0;
  end

endmodule
